// File: rtl/prog_bus_arbiter_if.sv
// prog_bus_arbiter_if
//   Bundles every non-clock signal of the programming bus arbiter: the
//   programmer/CPU ownership handshake, the two requester-side memory ports
//   and the muxed memory-side port.
//
//   Handshake semantics: prg_req (or force_prg) asks for ownership. The
//   arbiter raises cpu_halt_req and waits for cpu_halted, or for a drain
//   timeout. It then raises prg_grant. Ownership returns to the CPU after
//   HOLD_CYC consecutive quiet cycles. cpu_rst pulses on hand-back if the
//   window saw a write.
//
//   Modports:
//     slave  - the arbiter's view (requests and ports in, grant/muxed bus out)
//     master - the environment's view (the mirror image)
//   Parameters: CADD_W/CDAT_W code address/word width,
//               DADD_W/DDAT_W data address/word width.
interface prog_bus_arbiter_if #(
    parameter int CADD_W = 12,
    parameter int CDAT_W = 8,
    parameter int DADD_W = 11,
    parameter int DDAT_W = 16
);
    // ownership handshake
    logic              prg_req;
    logic              force_prg;
    logic              cpu_halted;
    logic              cpu_halt_req;
    logic              cpu_rst;
    logic              prg_grant;
    logic              drain_err;
    logic              drop_flag;
    // programmer side
    logic [CADD_W-1:0] p_cadd;
    logic [CDAT_W-1:0] p_cdat;
    logic              p_cwe;
    logic [DADD_W-1:0] p_dadd;
    logic [DDAT_W-1:0] p_ddat;
    logic              p_dwe;
    logic              p_stb;
    // CPU side
    logic [CADD_W-1:0] c_cadd;
    logic [DADD_W-1:0] c_dadd;
    logic [DDAT_W-1:0] c_ddat;
    logic              c_dwe;
    logic              c_stb;
    // memory side
    logic [CADD_W-1:0] m_cadd;
    logic [CDAT_W-1:0] m_cdat;
    logic              m_cwe;
    logic [DADD_W-1:0] m_dadd;
    logic [DDAT_W-1:0] m_ddat;
    logic              m_dwe;
    logic              m_en;

    modport slave (
        input  prg_req, force_prg, cpu_halted,
        input  p_cadd, p_cdat, p_cwe, p_dadd, p_ddat, p_dwe, p_stb,
        input  c_cadd, c_dadd, c_ddat, c_dwe, c_stb,
        output cpu_halt_req, cpu_rst, prg_grant, drain_err, drop_flag,
        output m_cadd, m_cdat, m_cwe, m_dadd, m_ddat, m_dwe, m_en
    );

    modport master (
        output prg_req, force_prg, cpu_halted,
        output p_cadd, p_cdat, p_cwe, p_dadd, p_ddat, p_dwe, p_stb,
        output c_cadd, c_dadd, c_ddat, c_dwe, c_stb,
        input  cpu_halt_req, cpu_rst, prg_grant, drain_err, drop_flag,
        input  m_cadd, m_cdat, m_cwe, m_dadd, m_ddat, m_dwe, m_en
    );
endinterface

// File: rtl/prog_bus_arbiter.sv
// prog_bus_arbiter
//   Shares the code ROM and data RAM between the Nano CPU and the SPI
//   programming slave. The CPU is halted at an instruction boundary before
//   the programmer gets the buses. The buses go back to the CPU after
//   programmer silence, with a one-cycle CPU restart if anything was written.
//
//   Ports:
//     clk        system clock
//     rst        asynchronous reset, active-high
//     bus        prog_bus_arbiter_if.slave (handshake, requester ports, memory port)
//     dbg_state  current arbiter state (CPU_OWN=0, DRAIN=1, PRG_OWN=2, RELEASE=3)
//   Parameters:
//     HOLD_CYC   consecutive quiet cycles before hand-back (>=2)
//     DRAIN_MAX  cycles waited for cpu_halted before a forced grant (>=1)
//   The bus widths come from the interface instance.
module prog_bus_arbiter #(
    parameter int HOLD_CYC  = 16,
    parameter int DRAIN_MAX = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    prog_bus_arbiter_if.slave    bus,
    output logic [1:0]           dbg_state
);

    localparam int IDLE_W = $clog2(HOLD_CYC);
    localparam int DRN_W  = $clog2(DRAIN_MAX + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(HOLD_CYC - 1);
    localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(DRAIN_MAX - 1);

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        DRAIN   = 2'd1,
        PRG_OWN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t              state;
    logic                halt_req;
    logic                rst_pulse;
    logic                grant;
    logic                drain_err;
    logic                drop;
    logic                wr_seen;
    logic [DRN_W-1:0]    drain_cnt;
    logic [IDLE_W-1:0]   idle_cnt;

    logic prg_active;
    assign prg_active = bus.prg_req | bus.p_stb | bus.force_prg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CPU_OWN;
            halt_req  <= 1'b0;
            rst_pulse <= 1'b0;
            grant     <= 1'b0;
            drain_err <= 1'b0;
            drop      <= 1'b0;
            wr_seen   <= 1'b0;
            drain_cnt <= '0;
            idle_cnt  <= '0;
        end else begin
            // A strobe from whichever side does not own the bus never reaches
            // memory (m_en follows the owner). Only the event is recorded here.
            if ((bus.p_stb && !grant) || (bus.c_stb && grant)) begin
                drop <= 1'b1;
            end

            case (state)
                CPU_OWN: begin
                    if (bus.prg_req || bus.force_prg) begin
                        state     <= DRAIN;
                        halt_req  <= 1'b1;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    // cpu_halted is tested first so that it wins over a
                    // simultaneous timeout and no error is flagged.
                    if (bus.cpu_halted) begin
                        state    <= PRG_OWN;
                        grant    <= 1'b1;
                        idle_cnt <= '0;
                    end else if (drain_cnt == DRN_LAST) begin
                        state     <= PRG_OWN;
                        grant     <= 1'b1;
                        idle_cnt  <= '0;
                        drain_err <= 1'b1;
                    end else if (drain_cnt != '1) begin
                        drain_cnt <= drain_cnt + DRN_W'(1);
                    end
                end
                PRG_OWN: begin
                    if (bus.p_stb && (bus.p_cwe || bus.p_dwe)) begin
                        wr_seen <= 1'b1;
                    end
                    if (prg_active) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        state     <= RELEASE;
                        grant     <= 1'b0;
                        halt_req  <= 1'b0;
                        rst_pulse <= wr_seen;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                RELEASE: begin
                    // CPU_OWN re-checks prg_req next cycle, so a programmer
                    // that is already back is not locked out.
                    rst_pulse <= 1'b0;
                    wr_seen   <= 1'b0;
                    state     <= CPU_OWN;
                end
                default: state <= CPU_OWN;
            endcase
        end
    end

    assign bus.cpu_halt_req = halt_req;
    assign bus.cpu_rst      = rst_pulse;
    assign bus.prg_grant    = grant;
    assign bus.drain_err    = drain_err;
    assign bus.drop_flag    = drop;
    assign dbg_state        = state;

    // Memory-side mux steered by the registered grant; no added latency.
    // The CPU has no code write path, so m_cdat is zero while it owns.
    assign bus.m_cadd = grant ? bus.p_cadd : bus.c_cadd;
    assign bus.m_cdat = grant ? bus.p_cdat : '0;
    assign bus.m_cwe  = grant & bus.p_cwe;
    assign bus.m_dadd = grant ? bus.p_dadd : bus.c_dadd;
    assign bus.m_ddat = grant ? bus.p_ddat : bus.c_ddat;
    assign bus.m_dwe  = grant ? bus.p_dwe  : bus.c_dwe;
    assign bus.m_en   = grant ? bus.p_stb  : bus.c_stb;

endmodule
